// File: rtl/procesador_pio_pkg.sv
// Shared register offsets and edge-select codes for the status input PIO.
package procesador_pio_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_RSVD    = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/procesador_input_debounce.sv
// One status line: 2-flop synchronizer, debounce counter and accepted-value flop.
// rise/fall pulse on the cycle whose clock edge updates stable.
module procesador_input_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Count cycles the synchronized input disagrees with the accepted value
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = (s2_q != stable_q) && (cnt_q == CNT_LAST);
    if (s2_q != stable_q) begin
      if (accept) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter and accepted value; reset abandons any pending count
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = accept & s2_q;
  assign fall   = accept & ~s2_q;

endmodule

// File: rtl/procesador_status_in.sv
// Avalon-MM status input PIO: debounced lines, edge capture, maskable level irq.
module procesador_status_in
  import procesador_pio_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int DEBOUNCE  = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, rise, fall, cap, clr;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rd_word;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    procesador_input_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign unused_wdata = ^writedata;

  // Pick which debounced transitions count as captured edges
  always_comb begin
    cap = rise;
    case (EDGE_TYPE)
      EDGE_FALLING: cap = fall;
      EDGE_ANY:     cap = rise | fall;
      default:      cap = rise;
    endcase
  end

  // Register writes; a fresh capture wins over a same-cycle write-1-to-clear
  always_comb begin
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en && (address == REG_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && (address == REG_EDGECAP)) clr = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr) | cap;
  end

  // Read mux samples pre-edge register values; readdata holds between reads
  always_comb begin
    rd_word    = '0;
    readdata_d = readdata_q;
    case (address)
      REG_DATA:    rd_word[WIDTH-1:0] = stable;
      REG_RSVD:    rd_word = '0;
      REG_IRQMASK: rd_word[WIDTH-1:0] = irqmask_q;
      REG_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
      default:     rd_word = '0;
    endcase
    if (rd_en) readdata_d = rd_word;
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_procesador_status_in.sv
// Directed bench: DUT a uses rising capture, DUT b any-edge capture.
module tb_procesador_status_in;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, rn_a, rn_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic [3:0]  in_a, in_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;
  logic [31:0] held;

  always #5 clk = ~clk;

  procesador_status_in #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset_a), .address(addr_a), .chipselect(cs_a),
    .read_n(rn_a), .write_n(wn_a), .writedata(wd_a), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a)
  );

  procesador_status_in #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset_b), .address(addr_b), .chipselect(cs_b),
    .read_n(rn_b), .write_n(wn_b), .writedata(wd_b), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
    if (sel) begin addr_b = a; cs_b = 1'b1; rn_b = 1'b0; end
    else     begin addr_a = a; cs_a = 1'b1; rn_a = 1'b0; end
    tick(1);
    cs_a = 1'b0; rn_a = 1'b1; cs_b = 1'b0; rn_b = 1'b1;
    d = sel ? rd_b : rd_a;
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    if (sel) begin addr_b = a; wd_b = d; cs_b = 1'b1; wn_b = 1'b0; end
    else     begin addr_a = a; wd_a = d; cs_a = 1'b1; wn_a = 1'b0; end
    tick(1);
    cs_a = 1'b0; wn_a = 1'b1; cs_b = 1'b0; wn_b = 1'b1;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    addr_a = '0; addr_b = '0; cs_a = 1'b0; cs_b = 1'b0;
    rn_a = 1'b1; rn_b = 1'b1; wn_a = 1'b1; wn_b = 1'b1;
    wd_a = '0; wd_b = '0; in_a = '0; in_b = '0;
    tick(3);
    reset_a = 1'b0; reset_b = 1'b0;

    // 1. reset state
    check("rst_irq_a", {31'd0, irq_a}, 32'd0);
    check("rst_rdata_a", rd_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b0, 2'(i), rv);
      check($sformatf("rst_reg%0d", i), rv, 32'd0);
    end

    // 2. lines 0 and 2 rise; capture lands exactly four edges after s2
    bus_write(1'b0, 2'd2, 32'h0000_000F);
    bus_read(1'b0, 2'd2, rv);
    check("mask_rb", rv, 32'h0000_000F);
    in_a = 4'b0101;
    tick(5);
    check("irq_before_e5", {31'd0, irq_a}, 32'd0);
    tick(1);
    check("irq_at_e5", {31'd0, irq_a}, 32'd1);
    bus_read(1'b0, 2'd0, rv);
    check("data_5", rv, 32'd5);
    held = rv;
    tick(2);
    check("rdata_hold", rd_a, held);
    bus_read(1'b0, 2'd3, rv);
    check("edgecap_5", rv, 32'd5);
    bus_write(1'b0, 2'd3, 32'h1);
    bus_read(1'b0, 2'd3, rv);
    check("edgecap_w1c", rv, 32'd4);
    check("irq_still", {31'd0, irq_a}, 32'd1);
    bus_write(1'b0, 2'd1, 32'hFFFF_FFFF);
    bus_read(1'b0, 2'd1, rv);
    check("rsvd_zero", rv, 32'd0);

    // 3. 3-cycle glitch rejected, 4-cycle pulse accepted
    bus_write(1'b0, 2'd3, 32'hF);
    check("irq_clr", {31'd0, irq_a}, 32'd0);
    in_a = 4'b0100;
    tick(3);
    in_a = 4'b0101;
    tick(10);
    bus_read(1'b0, 2'd0, rv);
    check("glitch_data", rv, 32'd5);
    bus_read(1'b0, 2'd3, rv);
    check("glitch_cap", rv, 32'd0);
    in_a = 4'b0100;
    tick(4);
    in_a = 4'b0101;
    tick(2);
    bus_read(1'b0, 2'd0, rv);
    check("pulse_data_low", rv, 32'd4);
    bus_read(1'b0, 2'd3, rv);
    check("fall_not_cap", rv, 32'd0);
    tick(8);
    bus_read(1'b0, 2'd0, rv);
    check("pulse_data_back", rv, 32'd5);
    bus_read(1'b0, 2'd3, rv);
    check("rise_cap_b0", rv, 32'd1);

    // 4. capture of bit1 on the same edge as its W1C
    bus_write(1'b0, 2'd3, 32'hF);
    in_a = 4'b0111;
    tick(5);
    bus_write(1'b0, 2'd3, 32'h2);
    bus_read(1'b0, 2'd3, rv);
    check("cap_vs_w1c", rv, 32'd2);
    check("cap_vs_w1c_irq", {31'd0, irq_a}, 32'd1);

    // 5. any-edge capture on DUT b, mask 0
    in_b = 4'b1000;
    tick(10);
    bus_read(1'b1, 2'd3, rv);
    check("any_rise", rv, 32'd8);
    check("any_irq_masked", {31'd0, irq_b}, 32'd0);
    bus_write(1'b1, 2'd3, 32'h8);
    bus_read(1'b1, 2'd3, rv);
    check("any_clr", rv, 32'd0);
    in_b = 4'b0000;
    tick(10);
    bus_read(1'b1, 2'd3, rv);
    check("any_fall", rv, 32'd8);
    check("any_irq_masked2", {31'd0, irq_b}, 32'd0);
    bus_write(1'b1, 2'd2, 32'h8);
    check("any_irq_unmask", {31'd0, irq_b}, 32'd1);

    // 6. reset during a pending count on DUT a
    in_a = 4'b1000;
    tick(4);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0;
    check("mid_rst_irq", {31'd0, irq_a}, 32'd0);
    check("mid_rst_rdata", rd_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b0, 2'(i), rv);
      check($sformatf("mid_rst_reg%0d", i), rv, 32'd0);
    end
    bus_write(1'b0, 2'd2, 32'hF);
    check("mid_rst_e4_irq", {31'd0, irq_a}, 32'd0);
    tick(1);
    check("mid_rst_e5_irq", {31'd0, irq_a}, 32'd1);
    bus_read(1'b0, 2'd3, rv);
    check("mid_rst_cap", rv, 32'd8);
    bus_read(1'b0, 2'd0, rv);
    check("mid_rst_data", rv, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
